// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral exposing a small register file; pins are oversampled in clk.
// Frame: R/W bit, address, data (MSB first); writes commit a few clk cycles after cs_n rises.
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         copi,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, CMD, DATA, OVF, COMMIT} state_t;

  logic [2:0]                 cs_sync_q;
  logic [2:0]                 sclk_sync_q;
  logic [1:0]                 copi_sync_q;
  logic [1:0]                 settle_q;
  logic                       armed_q;

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [FRAME_W-1:0]         shift_q;
  logic [FRAME_W-1:0]         shift_d;
  logic [DATA_W-1:0]          tx_q;
  logic [DATA_W-1:0]          rdata_d;
  logic                       ovf_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       wr_pulse_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic                       frame_err_q;

  logic                       cs_fall, cs_rise, sclk_rise, sclk_fall, copi_s;
  logic                       cmd_rd, fr_ok;
  logic [ADDR_W-1:0]          rd_addr, fr_addr;

  // armed_q blocks the fake cs_n fall seen when cs_n is already low as reset releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      copi_sync_q <= 2'b00;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      copi_sync_q <= {copi_sync_q[0], copi};
      settle_q    <= {settle_q[0], 1'b1};
      armed_q     <= armed_q | (settle_q[1] & cs_sync_q[1]);
    end
  end

  assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1] & armed_q;
  assign cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign copi_s    = copi_sync_q[1];

  always_comb begin
    shift_d = {shift_q[FRAME_W-2:0], copi_s};
    rd_addr = shift_d[ADDR_W-1:0];
    cmd_rd  = ~shift_d[ADDR_W];
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rdata_d = regs_q[i*DATA_W +: DATA_W];
    end
    fr_addr = shift_q[DATA_W +: ADDR_W];
    fr_ok   = ~ovf_q && (cnt_q == CNT_W'(FRAME_W)) &&
              ({1'b0, fr_addr} < (ADDR_W+1)'(NUM_REGS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ovf_q       <= 1'b0;
      regs_q      <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_fall) begin
        state_q <= CMD;
        cnt_q   <= '0;
        shift_q <= '0;
        tx_q    <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          CMD, DATA: begin
            if (cs_rise) begin
              state_q <= COMMIT;
              tx_q    <= '0;
            end else if (sclk_rise) begin
              if (cnt_q == CNT_W'(FRAME_W)) begin
                state_q <= OVF;
                ovf_q   <= 1'b1;
                tx_q    <= '0;
              end else begin
                shift_q <= shift_d;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (state_q == CMD && cnt_q == CNT_W'(CMD_W - 1)) begin
                  state_q <= DATA;
                  if (cmd_rd) tx_q <= rdata_d;
                end
              end
            // first fall of DATA is where the MSB goes out, so it must not shift
            end else if (sclk_fall && state_q == DATA && cnt_q > CNT_W'(CMD_W)) begin
              tx_q <= tx_q << 1;
            end
          end
          OVF: begin
            if (cs_rise) state_q <= COMMIT;
          end
          COMMIT: begin
            state_q <= IDLE;
            if (fr_ok) begin
              if (shift_q[FRAME_W-1]) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (fr_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
                end
                wr_pulse_q <= 1'b1;
                wr_addr_q  <= fr_addr;
              end
            end else if (ovf_q || cnt_q != '0) begin
              frame_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cipo      = tx_q[DATA_W-1];
  assign regs      = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
